alu32_unit: RTL and testbench
=============================

// Module: alu32_unit
// PURPOSE
//  32-bit MIPS-style integer ALU: add/sub (signed and unsigned), logic, set-less-than and variable shifts.
//  Sits in the execute stage. The op field carries the R-type funct code.
//  Result and flags are registered, so the ALU adds one cycle of latency.
// PARAMETERS
//  none. Widths are fixed: data 32, op 11.
// PORTS
//  clk       in   1   clock; all state updates on the rising edge
//  rst       in   1   synchronous, active-high reset
//  op        in   11  operation select; op[5:0] = funct, op[10:6] = shamt
//  in0       in   32  operand A; value to be shifted for shifts
//  in1       in   32  operand B; shift amount in in1[4:0] for variable shifts
//  carryout  out  1   carry (add) or borrow (sub)
//  overflow  out  1   signed overflow (add/sub only)
//  zero      out  1   registered out == 0
//  out       out  32  result
// BEHAVIOUR
//  Reset and latency:
//  - When rst=1 at a clock edge: out=0, carryout=0, overflow=0, zero=1.
//  - Otherwise all outputs register the combinational result of the op/in0/in1 sampled at that edge.
//  - Latency is 1 cycle, throughput is 1 op/cycle, and there is no handshake.
//  Decode compares the full 11 bits of op. Any unlisted code gives out=0, carryout=0, overflow=0, zero=1.
//  Op codes:
//  - 0x020 add : out = in0+in1 mod 2^32; carryout = bit 32 of the sum; overflow = signed overflow.
//  - 0x021 addu: same sum and carryout; overflow=0.
//  - 0x022 sub : out = in0-in1; carryout = borrow (in0 <u in1); overflow = signed overflow.
//  - 0x023 subu: same difference and borrow; overflow=0.
//  - 0x024 and, 0x025 or, 0x026 xor, 0x027 nor: bitwise; carryout=0, overflow=0.
//  - 0x02A slt : out = {31'b0, signed in0<in1}. Must be correct even when in0-in1 overflows.
//  - 0x02B sltu: out = {31'b0, unsigned in0<in1}.
//  - 0x004 shl: out = in0 << in1[4:0]; in1[31:5] are ignored.
//  - 0x006 shr: logical right shift of in0 by in1[4:0].
//  - 0x007 sar: arithmetic right shift of in0 by in1[4:0], replicating in0[31].
//  - Logic, slt/sltu and shift ops all force carryout=0 and overflow=0.
//  Results always wrap; overflow is a flag only and never suppresses the result.
//  Shift by 0 passes in0 through unchanged.
// CONFIGURATION
//  ALU32_SHAMT_EN defined:
//  - Adds immediate shifts: sll (op[5:0]=0x00), srl (0x02), sra (0x03).
//  - Shift amount comes from op[10:6]; in1 is ignored.
//  - For all other ops, op[10:6] must be 0 or the code is treated as unlisted.
//  ALU32_SHAMT_EN undefined: those codes are unlisted (zero result, zero=1).
// STRUCTURE
//  - Package alu32_pkg holds the localparam funct/op codes and a typedef for the 11-bit op.
//  - Sub-module alu32_shifter: combinational 32-bit barrel shifter.
//    Inputs: data, amt[4:0], dir, arith. Shared by all shift ops.
//  - The adder, logic, compare and decode stay in alu32_unit.
// TESTING (check outputs 1 cycle after applying inputs)
//  - rst=1 with any inputs -> out=0, carryout=0, overflow=0, zero=1; rst=0 -> normal results the next cycle.
//  - add 7fffffff+70000001 -> out=f0000000, overflow=1, carryout=0.
//  - add ffffffff+00000001 -> out=0, carryout=1, zero=1, overflow=0.
//  - sub 7fffffff-f0000001 -> out=8ffffffe, overflow=1, carryout=1.
//  - subu with the same operands -> out=8ffffffe, carryout=1, overflow=0.
//  - slt f0001231,7ac34545 -> out=1; sltu with the same operands -> out=0.
//  - nor 123451ff,60000000 -> out=8dcbae00.
//  - shl ffffffff by 5 -> ffffffe0; shr ffffffff by 5 -> 07ffffff.
//  - sar ffffffff by 3 -> ffffffff; sar 0fffffff by 5 -> 007fffff.
//  - Unlisted op 0x7FF -> out=0, zero=1.

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared definitions for the 32-bit ALU: op code type and funct/op codes.
package alu32_pkg;

  typedef logic [10:0] alu_op_t;

  // Register-operand ops: shamt field is zero, so the full 11-bit code is fixed.
  localparam alu_op_t OP_ADD  = 11'h020;
  localparam alu_op_t OP_ADDU = 11'h021;
  localparam alu_op_t OP_SUB  = 11'h022;
  localparam alu_op_t OP_SUBU = 11'h023;
  localparam alu_op_t OP_AND  = 11'h024;
  localparam alu_op_t OP_OR   = 11'h025;
  localparam alu_op_t OP_XOR  = 11'h026;
  localparam alu_op_t OP_NOR  = 11'h027;
  localparam alu_op_t OP_SLT  = 11'h02A;
  localparam alu_op_t OP_SLTU = 11'h02B;
  localparam alu_op_t OP_SHL  = 11'h004;
  localparam alu_op_t OP_SHR  = 11'h006;
  localparam alu_op_t OP_SAR  = 11'h007;

  // Immediate-shift funct codes; the amount lives in op[10:6].
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;

  // True for any funct that selects an immediate shift.
  function automatic logic is_imm_shift(input alu_op_t op);
    return (op[5:0] == FUNCT_SLL) || (op[5:0] == FUNCT_SRL) || (op[5:0] == FUNCT_SRA);
  endfunction

endpackage

// File: rtl/alu32_shifter.sv
// Combinational 32-bit barrel shifter shared by every shift op.
// dir=0 shifts left, dir=1 shifts right; arith=1 fills right shifts with data[31].
module alu32_shifter
  import alu32_pkg::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  input  logic        dir,
  input  logic        arith,
  output logic [31:0] result
);

  logic [31:0] data_rev;
  logic [31:0] stage [0:5];
  logic [31:0] stage_rev;
  logic        fill;

  // Left shifts reuse the right-shift network on bit-reversed data.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev
      assign data_rev[gi]  = data[31-gi];
      assign stage_rev[gi] = stage[5][31-gi];
    end
  endgenerate

  assign fill     = arith & dir & data[31];
  assign stage[0] = dir ? data : data_rev;

  // Log-depth right shifter: stage gi shifts by 2**gi when amt[gi] is set.
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage[gi+1] = amt[gi] ? {{SH{fill}}, stage[gi][31:SH]} : stage[gi];
    end
  endgenerate

  assign result = dir ? stage[5] : stage_rev;

endmodule

// File: rtl/alu32_unit.sv
// 32-bit MIPS-style ALU with registered result and flags (1-cycle latency).
// Optional immediate shifts (sll/srl/sra with amount in op[10:6]) are enabled
// by defining ALU32_SHAMT_EN; without it those codes decode as unlisted.
module alu32_unit
  import alu32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        carryout,
  output logic        overflow,
  output logic        zero,
  output logic [31:0] out
);

  logic [32:0] sum_ext;
  logic [32:0] diff_ext;
  logic        add_ovf;
  logic        sub_ovf;
  logic        lt_signed;
  logic        lt_unsigned;

  logic [4:0]  sh_amt;
  logic        sh_dir;
  logic        sh_arith;
  logic [31:0] sh_result;

  logic [31:0] res_next;
  logic        carry_next;
  logic        ovf_next;

  // One 33-bit adder and subtractor; bit 32 gives carry and borrow directly.
  assign sum_ext  = {1'b0, in0} + {1'b0, in1};
  assign diff_ext = {1'b0, in0} - {1'b0, in1};

  assign add_ovf = (in0[31] == in1[31]) && (sum_ext[31] != in0[31]);
  assign sub_ovf = (in0[31] != in1[31]) && (diff_ext[31] != in0[31]);

  // Signed compare from the sign bits when they differ, so a wrapped difference never misleads it.
  assign lt_signed   = (in0[31] != in1[31]) ? in0[31] : diff_ext[31];
  assign lt_unsigned = diff_ext[32];

  // Shifter control: variable shifts take in1[4:0], immediate shifts take op[10:6].
  always_comb begin
    sh_amt   = in1[4:0];
    sh_dir   = (op == OP_SHR) || (op == OP_SAR);
    sh_arith = (op == OP_SAR);
`ifdef ALU32_SHAMT_EN
    if (is_imm_shift(op)) begin
      sh_amt   = op[10:6];
      sh_dir   = (op[5:0] != FUNCT_SLL);
      sh_arith = (op[5:0] == FUNCT_SRA);
    end
`endif
  end

  alu32_shifter u_shifter (
    .data   (in0),
    .amt    (sh_amt),
    .dir    (sh_dir),
    .arith  (sh_arith),
    .result (sh_result)
  );

  // Decode on the full 11-bit op; anything unlisted yields a zero result with clear flags.
  always_comb begin
    res_next   = 32'd0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (op)
      OP_ADD:  begin res_next = sum_ext[31:0];  carry_next = sum_ext[32];  ovf_next = add_ovf; end
      OP_ADDU: begin res_next = sum_ext[31:0];  carry_next = sum_ext[32];  end
      OP_SUB:  begin res_next = diff_ext[31:0]; carry_next = diff_ext[32]; ovf_next = sub_ovf; end
      OP_SUBU: begin res_next = diff_ext[31:0]; carry_next = diff_ext[32]; end
      OP_AND:  res_next = in0 & in1;
      OP_OR:   res_next = in0 | in1;
      OP_XOR:  res_next = in0 ^ in1;
      OP_NOR:  res_next = ~(in0 | in1);
      OP_SLT:  res_next = {31'd0, lt_signed};
      OP_SLTU: res_next = {31'd0, lt_unsigned};
      OP_SHL, OP_SHR, OP_SAR: res_next = sh_result;
      default: begin
`ifdef ALU32_SHAMT_EN
        if (is_imm_shift(op)) begin
          res_next = sh_result;
        end
`endif
      end
    endcase
  end

  // Output register: reset forces a zero result with zero flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= 32'd0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      out      <= res_next;
      carryout <= carry_next;
      overflow <= ovf_next;
      zero     <= (res_next == 32'd0);
    end
  end

endmodule

// File: tb/tb_alu32_unit.sv
// Directed self-checking bench for alu32_unit using an expected-result queue.
module tb_alu32_unit;

  logic        clk;
  logic        rst;
  logic [10:0] op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        carryout;
  logic        overflow;
  logic        zero;
  logic [31:0] out;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_assert;
  int   n_fail;

  alu32_unit dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .in0      (in0),
    .in1      (in1),
    .carryout (carryout),
    .overflow (overflow),
    .zero     (zero),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation and push its expected registered result.
  task automatic drive(input logic r, input logic [10:0] o, input logic [31:0] a,
                       input logic [31:0] b, input string tag, input logic [31:0] eres,
                       input logic ec, input logic ev);
    exp_t e;
    rst = r;
    op  = o;
    in0 = a;
    in1 = b;
    e.tag = tag;
    e.res = eres;
    e.c   = ec;
    e.v   = ev;
    e.z   = (eres == 32'd0);
    sb.push_back(e);
  endtask

  // Let the edge capture the inputs, then compare 1 time unit later.
  task automatic check();
    exp_t e;
    @(posedge clk);
    #1;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    n_assert++;
    assert (out === e.res) else begin
      n_fail++;
      $error("FAIL %s out observed=%h expected=%h", e.tag, out, e.res);
    end
    n_assert++;
    assert (carryout === e.c) else begin
      n_fail++;
      $error("FAIL %s carryout observed=%b expected=%b", e.tag, carryout, e.c);
    end
    n_assert++;
    assert (overflow === e.v) else begin
      n_fail++;
      $error("FAIL %s overflow observed=%b expected=%b", e.tag, overflow, e.v);
    end
    n_assert++;
    assert (zero === e.z) else begin
      n_fail++;
      $error("FAIL %s zero observed=%b expected=%b", e.tag, zero, e.z);
    end
    $display("txn %-12s op=%h in0=%h in1=%h -> out=%h c=%b v=%b z=%b",
             e.tag, op, in0, in1, out, carryout, overflow, zero);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; op = 11'h020; in0 = 32'hffffffff; in1 = 32'h1;
    @(posedge clk);
    #1;

    drive(1'b1, 11'h020, 32'hffffffff, 32'h00000001, "reset_add",  32'h0, 1'b0, 1'b0); check();
    drive(1'b1, 11'h022, 32'h7fffffff, 32'hf0000001, "reset_sub",  32'h0, 1'b0, 1'b0); check();

    drive(1'b0, 11'h020, 32'h7fffffff, 32'h70000001, "add_ovf",    32'hf0000000, 1'b0, 1'b1); check();
    drive(1'b0, 11'h020, 32'hffffffff, 32'h00000001, "add_carry",  32'h00000000, 1'b1, 1'b0); check();
    drive(1'b0, 11'h021, 32'h7fffffff, 32'h70000001, "addu",       32'hf0000000, 1'b0, 1'b0); check();
    drive(1'b0, 11'h022, 32'h7fffffff, 32'hf0000001, "sub_ovf",    32'h8ffffffe, 1'b1, 1'b1); check();
    drive(1'b0, 11'h023, 32'h7fffffff, 32'hf0000001, "subu",       32'h8ffffffe, 1'b1, 1'b0); check();
    drive(1'b0, 11'h022, 32'h12345678, 32'h12345678, "sub_equal",  32'h00000000, 1'b0, 1'b0); check();
    drive(1'b0, 11'h024, 32'hf0f0ff00, 32'h3c3c0ff0, "and",        32'h30300f00, 1'b0, 1'b0); check();
    drive(1'b0, 11'h025, 32'hf0f0ff00, 32'h3c3c0ff0, "or",         32'hfcfcfff0, 1'b0, 1'b0); check();
    drive(1'b0, 11'h026, 32'hf0f0ff00, 32'h3c3c0ff0, "xor",        32'hccccf0f0, 1'b0, 1'b0); check();
    drive(1'b0, 11'h027, 32'h123451ff, 32'h60000000, "nor",        32'h8dcbae00, 1'b0, 1'b0); check();
    drive(1'b0, 11'h02A, 32'hf0001231, 32'h7ac34545, "slt",        32'h00000001, 1'b0, 1'b0); check();
    drive(1'b0, 11'h02B, 32'hf0001231, 32'h7ac34545, "sltu",       32'h00000000, 1'b0, 1'b0); check();
    drive(1'b0, 11'h02A, 32'h80000000, 32'h00000001, "slt_wrap",   32'h00000001, 1'b0, 1'b0); check();
    drive(1'b0, 11'h02A, 32'h7fffffff, 32'hffffffff, "slt_wrap2",  32'h00000000, 1'b0, 1'b0); check();
    drive(1'b0, 11'h004, 32'hffffffff, 32'h00000005, "shl5",       32'hffffffe0, 1'b0, 1'b0); check();
    drive(1'b0, 11'h006, 32'hffffffff, 32'h00000005, "shr5",       32'h07ffffff, 1'b0, 1'b0); check();
    drive(1'b0, 11'h007, 32'hffffffff, 32'h00000003, "sar3",       32'hffffffff, 1'b0, 1'b0); check();
    drive(1'b0, 11'h007, 32'h0fffffff, 32'h00000005, "sar5",       32'h007fffff, 1'b0, 1'b0); check();
    drive(1'b0, 11'h007, 32'h80000010, 32'hffffffe4, "sar_hi_amt", 32'hf8000001, 1'b0, 1'b0); check();
    drive(1'b0, 11'h004, 32'h00000001, 32'h0000001f, "shl31",      32'h80000000, 1'b0, 1'b0); check();
    drive(1'b0, 11'h006, 32'hdeadbeef, 32'h00000020, "shr0",       32'hdeadbeef, 1'b0, 1'b0); check();
    drive(1'b0, 11'h7FF, 32'h12345678, 32'h9abcdef0, "unlisted",   32'h00000000, 1'b0, 1'b0); check();
    drive(1'b0, 11'h060, 32'h00000001, 32'h00000001, "add_shamt",  32'h00000000, 1'b0, 1'b0); check();
`ifdef ALU32_SHAMT_EN
    drive(1'b0, 11'h100, 32'h00000003, 32'hffffffff, "sll_imm4",   32'h00000030, 1'b0, 1'b0); check();
    drive(1'b0, 11'h0C3, 32'h80000000, 32'h00000000, "sra_imm3",   32'hf0000000, 1'b0, 1'b0); check();
`else
    drive(1'b0, 11'h100, 32'h00000003, 32'hffffffff, "sll_unlist", 32'h00000000, 1'b0, 1'b0); check();
    drive(1'b0, 11'h0C3, 32'h80000000, 32'h00000000, "sra_unlist", 32'h00000000, 1'b0, 1'b0); check();
`endif
    drive(1'b1, 11'h024, 32'hffffffff, 32'hffffffff, "reset_mid",  32'h0, 1'b0, 1'b0); check();
    drive(1'b0, 11'h025, 32'h00000000, 32'h00000000, "or_zero",    32'h00000000, 1'b0, 1'b0); check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
